// File: rtl/crack_dispatch.sv
// -----------------------------------------------------------------------------
// crack_dispatch
//
// Hands out fixed-size key blocks to two brute-force crack cores, collects
// their results and reports the lowest key that produced readable plaintext.
// The 24-bit key space is split into 2^(24-BLOCK_LOG2) blocks. Blocks are
// granted in ascending order. A hit stops all further dispatch, and the
// remaining cores are told to abort.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   en                    start pulse, honoured only while rdy=1
//   rdy                   1 = idle, a new search may be started
//   key, key_valid        result of the last search (held until next start)
//   abort                 level, asks both cores to drop their current block
//   req0/1                core i wants a new block (held until granted)
//   gnt0/1                one-cycle grant to core i
//   base0/1               first key of the granted block (live in gnt cycle,
//                         held afterwards)
//   done0/1, hit0/1       core i finished its block; hit qualifies done
//   hit_key0/1            passing key reported with done & hit
// -----------------------------------------------------------------------------
module crack_dispatch #(
    parameter int BLOCK_LOG2 = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic        abort,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [23:0] base0,
    output logic [23:0] base1,
    input  logic        done0,
    input  logic        done1,
    input  logic        hit0,
    input  logic        hit1,
    input  logic [23:0] hit_key0,
    input  logic [23:0] hit_key1
);

    // Stride between consecutive block bases.
    localparam logic [24:0] BLOCK_STEP = 25'(1) << BLOCK_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [24:0] next_base_q, next_base_d;   // bit 24 set = key space exhausted
    logic        busy0_q, busy0_d;
    logic        busy1_q, busy1_d;
    logic        pend_valid_q, pend_valid_d;
    logic [23:0] pend_key_q, pend_key_d;
    logic [23:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic [23:0] base0_q, base0_d;
    logic [23:0] base1_q, base1_d;
    logic        last_gnt1_q, last_gnt1_d;   // 1 = core 1 was granted most recently

    logic        done_ok0, done_ok1;
    logic        hit_ok0, hit_ok1;
    logic        cand_valid;
    logic [23:0] cand_key;
    logic        exhausted;
    logic        elig0, elig1;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        next_base_d  = next_base_q;
        busy0_d      = busy0_q;
        busy1_d      = busy1_q;
        pend_valid_d = pend_valid_q;
        pend_key_d   = pend_key_q;
        key_d        = key_q;
        key_valid_d  = key_valid_q;
        base0_d      = base0_q;
        base1_d      = base1_q;
        last_gnt1_d  = last_gnt1_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;

        // A done from a core that holds no block is stray and dropped whole,
        // hit included.
        done_ok0 = done0 & busy0_q;
        done_ok1 = done1 & busy1_q;
        hit_ok0  = done_ok0 & hit0;
        hit_ok1  = done_ok1 & hit1;

        // Lower of the (up to two) keys reported this cycle.
        cand_valid = hit_ok0 | hit_ok1;
        cand_key   = hit_key1;
        if (hit_ok0 && (!hit_ok1 || (hit_key0 < hit_key1))) begin
            cand_key = hit_key0;
        end

        if (cand_valid && (!pend_valid_q || (cand_key < pend_key_q))) begin
            pend_valid_d = 1'b1;
            pend_key_d   = cand_key;
        end

        if (done_ok0) busy0_d = 1'b0;
        if (done_ok1) busy1_d = 1'b0;

        // Dispatch: at most one grant per cycle; on a tie the core that was
        // not served last wins.
        exhausted = next_base_q[24];
        elig0     = (state_q == ST_RUN) && req0 && !busy0_q && !exhausted;
        elig1     = (state_q == ST_RUN) && req1 && !busy1_q && !exhausted;

        if (elig0 && (!elig1 || last_gnt1_q)) begin
            gnt0 = 1'b1;
        end else if (elig1) begin
            gnt1 = 1'b1;
        end

        if (gnt0) begin
            busy0_d     = 1'b1;
            base0_d     = next_base_q[23:0];
            next_base_d = next_base_q + BLOCK_STEP;
            last_gnt1_d = 1'b0;
        end
        if (gnt1) begin
            busy1_d     = 1'b1;
            base1_d     = next_base_q[23:0];
            next_base_d = next_base_q + BLOCK_STEP;
            last_gnt1_d = 1'b1;
        end

        // Exits to IDLE look at the next busy flags so rdy rises in the cycle
        // right after the last done pulse.
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d      = ST_RUN;
                    next_base_d  = '0;
                    busy0_d      = 1'b0;
                    busy1_d      = 1'b0;
                    key_valid_d  = 1'b0;
                    pend_valid_d = 1'b0;
                    pend_key_d   = '0;
                end
            end
            ST_RUN: begin
                if (cand_valid) begin
                    state_d = ST_DRAIN;
                end else if (exhausted && !busy0_d && !busy1_d) begin
                    state_d     = ST_IDLE;
                    key_d       = pend_key_d;
                    key_valid_d = pend_valid_d;
                end
            end
            ST_DRAIN: begin
                if (!busy0_d && !busy1_d) begin
                    state_d     = ST_IDLE;
                    key_d       = pend_key_d;
                    key_valid_d = pend_valid_d;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            next_base_q  <= '0;
            busy0_q      <= 1'b0;
            busy1_q      <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_key_q   <= '0;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            base0_q      <= '0;
            base1_q      <= '0;
            last_gnt1_q  <= 1'b1;   // core 0 wins the first tie
        end else begin
            state_q      <= state_d;
            next_base_q  <= next_base_d;
            busy0_q      <= busy0_d;
            busy1_q      <= busy1_d;
            pend_valid_q <= pend_valid_d;
            pend_key_q   <= pend_key_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            base0_q      <= base0_d;
            base1_q      <= base1_d;
            last_gnt1_q  <= last_gnt1_d;
        end
    end

    assign rdy       = (state_q == ST_IDLE);
    assign abort     = (state_q == ST_DRAIN);
    assign key       = key_q;
    assign key_valid = key_valid_q;
    // The base is presented combinationally in the grant cycle.
    assign base0     = gnt0 ? next_base_q[23:0] : base0_q;
    assign base1     = gnt1 ? next_base_q[23:0] : base1_q;

endmodule

// File: tb/tb_crack_dispatch.sv
// -----------------------------------------------------------------------------
// tb_crack_dispatch
//
// Bench for crack_dispatch (default BLOCK_LOG2 = 16, i.e. 256 blocks).
// A block-level model tracks which core owns a block, how many blocks were
// handed out and the best hit so far; it is compared to the DUT on every
// falling edge. Directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_crack_dispatch;

    localparam int BLOCK_LOG2 = 16;
    localparam int NBLK       = 1 << (24 - BLOCK_LOG2);
    localparam int BLOCK      = 1 << BLOCK_LOG2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic        key_valid;
    logic        abort;
    logic        req0, req1;
    logic        gnt0, gnt1;
    logic [23:0] base0, base1;
    logic        done0, done1;
    logic        hit0, hit1;
    logic [23:0] hit_key0, hit_key1;

    int n_vec  = 0;
    int n_miss = 0;

    crack_dispatch #(.BLOCK_LOG2(BLOCK_LOG2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rdy      (rdy),
        .key      (key),
        .key_valid(key_valid),
        .abort    (abort),
        .req0     (req0),
        .req1     (req1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .base0    (base0),
        .base1    (base1),
        .done0    (done0),
        .done1    (done1),
        .hit0     (hit0),
        .hit1     (hit1),
        .hit_key0 (hit_key0),
        .hit_key1 (hit_key1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // phase: 0 idle, 1 dispatching, 2 draining after a hit
    typedef struct {
        int phase;
        int issued;   // blocks handed out in this search
        bit busy0;
        bit busy1;
        int best;     // lowest hit key, -1 = none
        int key;
        bit kv;
        int favor;    // core that wins a tie
        int base0;
        int base1;
    } model_t;

    model_t m, mn;
    bit x_gnt0, x_gnt1;
    int x_base0, x_base1;

    function automatic model_t model_reset();
        model_t r;
        r.phase = 0; r.issued = 0; r.busy0 = 0; r.busy1 = 0; r.best = -1;
        r.key = 0; r.kv = 0; r.favor = 0; r.base0 = 0; r.base1 = 0;
        return r;
    endfunction

    task automatic model_eval();
        int  g;
        bit  any_hit;
        bit  e0, e1;
        mn = m;
        g  = -1;
        if (m.phase == 1 && m.issued < NBLK) begin
            e0 = req0 && !m.busy0;
            e1 = req1 && !m.busy1;
            if (e0 && e1)  g = m.favor;
            else if (e0)   g = 0;
            else if (e1)   g = 1;
        end
        x_gnt0  = (g == 0);
        x_gnt1  = (g == 1);
        x_base0 = (g == 0) ? m.issued * BLOCK : m.base0;
        x_base1 = (g == 1) ? m.issued * BLOCK : m.base1;

        any_hit = 0;
        if (done0 && m.busy0) begin
            mn.busy0 = 0;
            if (hit0) begin
                any_hit = 1;
                if (mn.best < 0 || int'(hit_key0) < mn.best) mn.best = int'(hit_key0);
            end
        end
        if (done1 && m.busy1) begin
            mn.busy1 = 0;
            if (hit1) begin
                any_hit = 1;
                if (mn.best < 0 || int'(hit_key1) < mn.best) mn.best = int'(hit_key1);
            end
        end
        if (g == 0) begin mn.busy0 = 1; mn.base0 = x_base0; end
        if (g == 1) begin mn.busy1 = 1; mn.base1 = x_base1; end
        if (g >= 0) begin mn.issued = m.issued + 1; mn.favor = 1 - g; end

        case (m.phase)
            0: if (en) begin
                mn.phase = 1; mn.issued = 0; mn.busy0 = 0; mn.busy1 = 0;
                mn.best = -1; mn.kv = 0;
            end
            1: if (any_hit) mn.phase = 2;
               else if (m.issued == NBLK && !mn.busy0 && !mn.busy1) mn.phase = 3;
            default: if (!mn.busy0 && !mn.busy1) mn.phase = 3;
        endcase
        if (mn.phase == 3) begin
            mn.phase = 0;
            mn.kv    = (mn.best >= 0);
            mn.key   = (mn.best >= 0) ? mn.best : 0;
        end
    endtask

    // Compare process: outputs checked on every falling edge.
    initial begin
        m = model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) m = model_reset();
            model_eval();
            check("m_rdy",   {31'd0, rdy},       {31'd0, (m.phase == 0)});
            check("m_abort", {31'd0, abort},     {31'd0, (m.phase == 2)});
            check("m_kv",    {31'd0, key_valid}, {31'd0, m.kv});
            check("m_key",   {8'd0, key},        m.key);
            check("m_gnt0",  {31'd0, gnt0},      {31'd0, x_gnt0});
            check("m_gnt1",  {31'd0, gnt1},      {31'd0, x_gnt1});
            check("m_base0", {8'd0, base0},      x_base0);
            check("m_base1", {8'd0, base1},      x_base1);
            @(posedge clk);
            if (rst_n) m = mn;
        end
    end

    // -------------------------------------------------------------- driver
    task automatic next_cycle();
        @(posedge clk);
        #1;
        en = 0; done0 = 0; done1 = 0; hit0 = 0; hit1 = 0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        rst_n = 0; req0 = 0; req1 = 0;
        next_cycle();
        next_cycle();
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  ngr;
        int  last_base;
        bit  seen0, seen1;
        int  cnt0, cnt1;
        bit  finished;

        rst_n = 0; en = 0; req0 = 0; req1 = 0; done0 = 0; done1 = 0;
        hit0 = 0; hit1 = 0; hit_key0 = '0; hit_key1 = '0;

        // ---- reset state
        repeat (2) @(posedge clk);
        sample();
        check("rst_rdy",   {31'd0, rdy},       1);
        check("rst_key",   {8'd0, key},        0);
        check("rst_kv",    {31'd0, key_valid}, 0);
        check("rst_abort", {31'd0, abort},     0);
        check("rst_gnt",   {30'd0, gnt1, gnt0}, 0);
        check("rst_base0", {8'd0, base0},      0);
        check("rst_base1", {8'd0, base1},      0);
        next_cycle(); rst_n = 1;

        // ---- two grants, hit on core 1, drain core 0
        next_cycle(); en = 1;
        next_cycle(); req0 = 1; req1 = 1;
        sample();
        check("t1_gnt0",  {31'd0, gnt0}, 1);
        check("t1_base0", {8'd0, base0}, 32'h000000);
        check("t1_gnt1a", {31'd0, gnt1}, 0);
        check("t1_rdy",   {31'd0, rdy},  0);
        next_cycle(); req0 = 0;
        sample();
        check("t1_gnt1",  {31'd0, gnt1}, 1);
        check("t1_base1", {8'd0, base1}, 32'h010000);
        check("t1_gnt0b", {31'd0, gnt0}, 0);
        next_cycle(); req1 = 0;
        sample();
        check("t1_hold0", {8'd0, base0}, 32'h000000);
        check("t1_hold1", {8'd0, base1}, 32'h010000);
        next_cycle(); done1 = 1; hit1 = 1; hit_key1 = 24'h01ABCD;
        sample();
        check("t1_abort_pre", {31'd0, abort}, 0);
        next_cycle();
        sample();
        check("t1_abort", {31'd0, abort}, 1);
        next_cycle(); done0 = 1;
        sample();
        check("t1_abort2", {31'd0, abort}, 1);
        next_cycle();
        sample();
        check("t1_rdy_end", {31'd0, rdy},       1);
        check("t1_key",     {8'd0, key},        32'h01ABCD);
        check("t1_kv",      {31'd0, key_valid}, 1);
        check("t1_abort0",  {31'd0, abort},     0);

        // ---- ignored en / stray done, then simultaneous hits
        next_cycle(); en = 1;
        next_cycle(); req0 = 1;
        sample();
        check("t2_gnt0",  {31'd0, gnt0}, 1);
        check("t2_base0", {8'd0, base0}, 32'h000000);
        next_cycle(); req0 = 0; en = 1; done1 = 1; hit1 = 1; hit_key1 = 24'h000001;
        sample();
        check("t2_nogrant", {30'd0, gnt1, gnt0}, 0);
        next_cycle(); req1 = 1;
        sample();
        check("t2_gnt1",   {31'd0, gnt1},  1);
        check("t2_base1",  {8'd0, base1},  32'h010000);
        check("t2_noabort", {31'd0, abort}, 0);
        next_cycle(); req1 = 0;
        next_cycle();
        done0 = 1; hit0 = 1; hit_key0 = 24'h000123;
        done1 = 1; hit1 = 1; hit_key1 = 24'h010001;
        finished = 0;
        for (int i = 0; i < 10 && !finished; i++) begin
            next_cycle();
            sample();
            if (rdy) finished = 1;
        end
        check("t2_done",  {31'd0, finished},  1);
        check("t2_key",   {8'd0, key},        32'h000123);
        check("t2_kv",    {31'd0, key_valid}, 1);

        // ---- reset in the middle of a run
        next_cycle(); en = 1;
        next_cycle(); req0 = 1;
        sample();
        check("t4_gnt0", {31'd0, gnt0}, 1);
        next_cycle(); req0 = 0;
        next_cycle(); rst_n = 0; req0 = 1; req1 = 1;
        #1;
        check("t4_rdy",   {31'd0, rdy},        1);
        check("t4_gnt",   {30'd0, gnt1, gnt0}, 0);
        check("t4_abort", {31'd0, abort},      0);
        check("t4_key",   {8'd0, key},         0);
        check("t4_base0", {8'd0, base0},       0);
        next_cycle(); rst_n = 1; req0 = 0; req1 = 0;
        next_cycle(); done0 = 1;
        next_cycle();
        sample();
        check("t4_stray_rdy", {31'd0, rdy}, 1);
        next_cycle(); en = 1;
        next_cycle(); req0 = 1; req1 = 1;
        sample();
        check("t4_restart_gnt0",  {31'd0, gnt0}, 1);
        check("t4_restart_base0", {8'd0, base0}, 32'h000000);
        next_cycle(); req0 = 0; req1 = 0;

        // ---- full sweep, no hits
        do_reset();
        next_cycle(); en = 1;
        next_cycle(); req0 = 1; req1 = 1;
        ngr = 0; last_base = -1; cnt0 = 0; cnt1 = 0; finished = 0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            if (cyc > 0) begin
                next_cycle();
                if (seen0) begin
                    req0 = 0; cnt0 = 2;
                end else if (!req0) begin
                    cnt0--;
                    if (cnt0 == 0) begin done0 = 1; req0 = 1; end
                end
                if (seen1) begin
                    req1 = 0; cnt1 = 3;
                end else if (!req1) begin
                    cnt1--;
                    if (cnt1 == 0) begin done1 = 1; req1 = 1; end
                end
            end
            sample();
            seen0 = gnt0;
            seen1 = gnt1;
            if (gnt0) begin ngr++; last_base = int'(base0); end
            if (gnt1) begin ngr++; last_base = int'(base1); end
            if (rdy) finished = 1;
        end
        check("t3_finished",  {31'd0, finished},  1);
        check("t3_grants",    ngr,                256);
        check("t3_last_base", last_base,          32'hFF0000);
        check("t3_model_blk", m.issued,           256);
        check("t3_kv",        {31'd0, key_valid}, 0);
        next_cycle(); req0 = 0; req1 = 0;
        next_cycle();
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
